// File: rtl/mips_md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, controller states, HI/LO select.
package mips_md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Unsigned shift-add multiplier / restoring divider core, one iteration per step (MD_FAST_MUL_EN adds a one-shot product).
// Latency: WIDTH steps after load; raw outputs are valid once stepping has finished.
// Backpressure: none; the controller sequences load/step.
module md_datapath
    import mips_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] raw_hi,
    output logic [WIDTH-1:0] raw_lo
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, acc} + (qr[0] ? {1'b0, dvs} : '0);
        shifted = {acc, qr[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        ge      = (shifted >= {1'b0, dvs});
    end

    // acc is the product high half when multiplying and the partial remainder when dividing
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            qr  <= '0;
            dvs <= '0;
        end else if (load) begin
            acc <= '0;
            qr  <= a;
            dvs <= b;
        end else if (step) begin
            if (op_is_div(op)) begin
                acc <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                qr  <= {qr[WIDTH-2:0], ge};
            end else begin
                acc <= sum[WIDTH:1];
                qr  <= {sum[0], qr[WIDTH-1:1]};
            end
        end
    end

`ifdef MD_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, dvs} * {{WIDTH{1'b0}}, qr};
    assign raw_hi = op_is_div(op) ? acc : prod[2*WIDTH-1:WIDTH];
    assign raw_lo = op_is_div(op) ? qr  : prod[WIDTH-1:0];
`else
    assign raw_hi = acc;
    assign raw_lo = qr;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS EX-stage mul/div controller owning HI/LO; MD_FAST_MUL_EN makes multiplies single-cycle.
// Latency: WIDTH+2 cycles from accepted start to new HI/LO and done (2 for fast multiply).
// Backpressure: stall asserted while busy and EX presents a mul/div, MFxx or MTxx.
module muldiv_ctrl
    import mips_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    input  logic             mf_sel,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic               neg_q, neg_r;
    logic               sa, sb, start;
    logic               dp_step, fix_wr, mt_wr;
    logic [WIDTH-1:0]   a_mag, b_mag, raw_hi, raw_lo, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign start = (state == IDLE) & md_start & ~flush;
    assign sa    = op_is_signed(md_op) & rs_val[WIDTH-1];
    assign sb    = op_is_signed(md_op) & rt_val[WIDTH-1];
    assign a_mag = sa ? -rs_val : rs_val;
    assign b_mag = sb ? -rt_val : rt_val;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
`ifdef MD_FAST_MUL_EN
                state_nxt = op_is_div(md_op) ? RUN : FIX;
`else
                state_nxt = RUN;
`endif
            end
            RUN:  if (flush) state_nxt = IDLE;
                  else if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        stall   = busy & (md_start | mf_req | mt_we);
        dp_step = (state == RUN) & ~flush;
        fix_wr  = (state == FIX) & ~flush;
        mt_wr   = (state == IDLE) & mt_we & ~md_start;
    end

    // Sign correction applied to the raw magnitudes on the way into HI/LO
    always_comb begin
        prod_fix = neg_q ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};
        if (op_is_div(op_q)) begin
            lo_fix = neg_q ? -raw_lo : raw_lo;
            hi_fix = neg_r ? -raw_hi : raw_hi;
        end else begin
            lo_fix = prod_fix[WIDTH-1:0];
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= fix_wr;
            if (start) begin
                cnt   <= CW'(WIDTH);
                op_q  <= md_op;
                neg_q <= sa ^ sb;
                neg_r <= sa;
            end else if (dp_step) begin
                cnt <= cnt - CW'(1);
            end
            if (fix_wr) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end else if (mt_wr) begin
                if (mt_sel == SEL_HI) hi <= mt_data;
                else                  lo <= mt_data;
            end
        end
    end

    assign mf_data = (mf_sel == SEL_HI) ? hi : lo;

    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .step   (dp_step),
        .op     (state == IDLE ? md_op : op_q),
        .a      (a_mag),
        .b      (b_mag),
        .raw_hi (raw_hi),
        .raw_lo (raw_lo)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed checks of muldiv_ctrl: reset, MT/MF, all four ops, stall timing, flush and reset abort.
module tb_muldiv_ctrl;
    import mips_md_pkg::*;

    localparam int W = 32;
`ifdef MD_FAST_MUL_EN
    localparam int         MUL_BUSY = 1;
    localparam logic [1:0] FLUSH_OP = MD_DIVU;
`else
    localparam int         MUL_BUSY = W + 1;
    localparam logic [1:0] FLUSH_OP = MD_MULT;
`endif
    localparam int DIV_BUSY = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         md_start, mf_req, mf_sel, mt_we, mt_sel, flush;
    logic [1:0]   md_op;
    logic [W-1:0] rs_val, rt_val, mt_data;
    logic         busy, stall, done;
    logic [W-1:0] mf_data, hi, lo;
    int           total = 0;
    int           bad = 0;
    int           n;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req), .mf_sel(mf_sel),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .mf_data(mf_data),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        md_start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1 chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
        cyc();
        md_start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (done !== 1'b0) chk({tag, "_done_early"}, 32'(done), 32'd0);
            cyc();
        end
        chk({tag, "_busy_len"}, 32'(cnt), 32'(exp_busy));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        cyc();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; md_start = 1'b0; md_op = MD_MULT; rs_val = '0; rt_val = '0;
        mf_req = 1'b0; mf_sel = SEL_LO; mt_we = 1'b0; mt_sel = SEL_LO; mt_data = '0; flush = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // MT writes land one cycle later
        mt_we = 1'b1; mt_sel = SEL_LO; mt_data = 32'h1234;
        #1 chk("mt_stall", 32'(stall), 32'd0);
        cyc();
        mt_we = 1'b0;
        chk("mtlo", lo, 32'h1234);
        chk("mtlo_hi_kept", hi, 32'd0);
        mt_we = 1'b1; mt_sel = SEL_HI; mt_data = 32'hA;
        cyc();
        mt_we = 1'b0; mf_sel = SEL_HI;
        #1 chk("mfhi_idle", mf_data, 32'hA);

        // MT in same cycle as a start is dropped
        mt_we = 1'b1; mt_sel = SEL_HI; mt_data = 32'hDEAD;
        md_start = 1'b1; md_op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd4;
        cyc();
        mt_we = 1'b0; md_start = 1'b0;
        chk("mt_drop_busy", 32'(busy), 32'd1);
        chk("mt_drop_hi", hi, 32'hA);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; cyc(); end
        chk("mt_drop_len", 32'(n), 32'(MUL_BUSY));
        chk("mt_drop_res_hi", hi, 32'd0);
        chk("mt_drop_res_lo", lo, 32'd12);

        run_op("mult_neg",   MD_MULT,  32'hFFFFFFFD, 32'd5,       MUL_BUSY, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'd2,       MUL_BUSY, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_7x6",   MD_MULT,  32'd7,        32'd6,       MUL_BUSY, 32'd0,        32'd42);
        run_op("div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2,       DIV_BUSY, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero",  MD_DIVU,  32'd9,        32'd0,       DIV_BUSY, 32'd9,        32'hFFFFFFFF);
        run_op("div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_BUSY, 32'd0,       32'h80000000);
        run_op("div_pos",    MD_DIV,   32'd100,      32'hFFFFFFF9, DIV_BUSY, 32'd2,       32'hFFFFFFF2);

        // flush with start in IDLE ignores the start
        md_start = 1'b1; flush = 1'b1; md_op = MD_DIV;
        cyc();
        md_start = 1'b0; flush = 1'b0;
        chk("flush_idle_start", 32'(busy), 32'd0);

        // MFHI raised at cycle 3 of a DIV stalls through cycle 33
        md_start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
        cyc();
        md_start = 1'b0;
        cyc();
        cyc();
        mf_req = 1'b1; mf_sel = SEL_HI;
        #1 chk("mf_stall_on", 32'(stall), 32'd1);
        n = 0;
        while (stall === 1'b1 && n < 100) begin n++; cyc(); end
        chk("mf_stall_len", 32'(n), 32'd31);
        chk("mf_hi_new", mf_data, 32'd2);
        chk("mf_done", 32'(done), 32'd1);
        mf_sel = SEL_LO;
        #1 chk("mf_lo_new", mf_data, 32'd14);
        mf_req = 1'b0;

        // held md_start is accepted in the cycle results appear
        md_start = 1'b1; md_op = MD_DIVU; rs_val = 32'd20; rt_val = 32'd3;
        cyc();
        md_op = MD_MULTU; rs_val = 32'd5; rt_val = 32'd6;
        n = 0;
        while (stall === 1'b1 && n < 100) begin n++; cyc(); end
        chk("b2b_stall_len", 32'(n), 32'(DIV_BUSY));
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_first_hi", hi, 32'd2);
        chk("b2b_first_lo", lo, 32'd6);
        cyc();
        md_start = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; cyc(); end
        chk("b2b_second_lo", lo, 32'd30);

        // flush at cycle 10 leaves HI/LO alone
        mt_we = 1'b1; mt_sel = SEL_HI; mt_data = 32'hA;
        cyc();
        mt_sel = SEL_LO; mt_data = 32'hB;
        cyc();
        mt_we = 1'b0;
        md_start = 1'b1; md_op = FLUSH_OP; rs_val = 32'd3; rt_val = 32'd4;
        cyc();
        md_start = 1'b0;
        repeat (9) cyc();
        chk("flush_busy_c10", 32'(busy), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_no_done", 32'(done), 32'd0);
        chk("flush_hi", hi, 32'hA);
        chk("flush_lo", lo, 32'hB);
        cyc();
        chk("flush_no_done_late", 32'(done), 32'd0);
        chk("flush_lo_late", lo, 32'hB);

        // reset at cycle 10 abandons the op
        md_start = 1'b1; md_op = FLUSH_OP;
        cyc();
        md_start = 1'b0;
        repeat (9) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; mf_req = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        mf_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
